// File: rtl/gray_code_cnt.sv
// gray_code_cnt: enable-gated binary up-counter with a registered Gray-code
// copy of the same state. Both outputs update on the same rising edge, so
// gray_code always equals count ^ (count >> 1).
//
// Optional build macro GRAY_CODE_CNT_ASSERT_EN compiles in concurrent
// assertions that check the Gray invariant, the single-bit step and the
// hold behaviour. It adds no logic that drives either output.
//
// Interface note: there is no handshake. en is a plain level qualifier
// sampled at each rising edge, and the outputs carry no backpressure.
module gray_code_cnt #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] gray_code
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  // Reflected-binary encoding of a binary value.
  function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  logic [WIDTH-1:0] count_next;
  logic [WIDTH-1:0] gray_next;

  // Next-state values; the Gray copy is derived from the incremented count
  // so both registers load a mutually consistent pair on the same edge.
  always_comb begin
    count_next = count + ONE;
    gray_next  = bin2gray(count_next);
  end

  // State registers: clear asynchronously, advance only when en is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count     <= '0;
      gray_code <= '0;
    end else if (en) begin
      count     <= count_next;
      gray_code <= gray_next;
    end
  end

`ifdef GRAY_CODE_CNT_ASSERT_EN
  // Copies of the previous edge's values. chk_valid is cleared by reset so
  // that the step checks never compare across a reset pulse.
  logic             chk_valid;
  logic             prev_en;
  logic [WIDTH-1:0] prev_gray;
  logic [WIDTH-1:0] prev_count;

  // Capture the values seen at each edge for the next edge's step checks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chk_valid  <= 1'b0;
      prev_en    <= 1'b0;
      prev_gray  <= '0;
      prev_count <= '0;
    end else begin
      chk_valid  <= 1'b1;
      prev_en    <= en;
      prev_gray  <= gray_code;
      prev_count <= count;
    end
  end

  a_gray_invariant : assert property (
    @(posedge clk) disable iff (!rst_n)
      gray_code == bin2gray(count)
  ) else $error("gray_code_cnt: gray/count mismatch at time %0t", $time);

  a_single_bit_step : assert property (
    @(posedge clk) disable iff (!rst_n)
      (chk_valid && prev_en) |-> ($countones(gray_code ^ prev_gray) == 1)
  ) else $error("gray_code_cnt: enabled step changed other than one bit at time %0t", $time);

  a_hold_when_idle : assert property (
    @(posedge clk) disable iff (!rst_n)
      (chk_valid && !prev_en) |-> (gray_code == prev_gray && count == prev_count)
  ) else $error("gray_code_cnt: outputs moved on a disabled edge at time %0t", $time);
`endif

endmodule

// File: tb/tb_gray_code_cnt.sv
// Self-checking bench for gray_code_cnt (WIDTH = 4).
module tb_gray_code_cnt;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic         en;
  logic [W-1:0] count;
  logic [W-1:0] gray_code;

  int tests_run;
  int tests_failed;

  // Hand-computed Gray sequence for count = 1..15,0.
  logic [W-1:0] gray_tbl [16] = '{4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4, 4'd12,
                                  4'd13, 4'd15, 4'd14, 4'd10, 4'd11, 4'd9, 4'd8, 4'd0};

  logic [W-1:0] exp_q [$];

  gray_code_cnt #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .count     (count),
    .gray_code (gray_code)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bit-by-bit Gray model: g[i] = b[i] ^ b[i+1], top bit copied.
  function automatic logic [W-1:0] model_gray(input logic [W-1:0] b);
    logic [W-1:0] g;
    g[W-1] = b[W-1];
    for (int i = 0; i < W - 1; i++) g[i] = b[i] ^ b[i+1];
    return g;
  endfunction

  // ---------------- driver tasks ----------------
  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    en    = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    en    = 1'b1;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (count !== 4'd0 || gray_code !== 4'd0) begin
      tests_failed++;
      $display("FAIL reset_initial: count=%0d gray=%0d required 0/0", count, gray_code);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      tests_run++;
      if (count !== 4'd0 || gray_code !== 4'd0) begin
        tests_failed++;
        $display("FAIL reset_hold[%0d]: count=%0d gray=%0d required 0/0", i, count, gray_code);
      end
    end
  endtask

  task automatic test_full_sequence();
    logic [W-1:0] prev_g;
    logic [W-1:0] exp_c;
    do_reset();
    en     = 1'b1;
    prev_g = 4'd0;
    for (int i = 0; i < 16; i++) begin
      step();
      exp_c = W'((i + 1) % 16);
      tests_run++;
      if (count !== exp_c) begin
        tests_failed++;
        $display("FAIL seq_count[%0d]: got %0d required %0d", i, count, exp_c);
      end
      tests_run++;
      if (gray_code !== gray_tbl[i]) begin
        tests_failed++;
        $display("FAIL seq_gray[%0d]: got %0d required %0d", i, gray_code, gray_tbl[i]);
      end
      tests_run++;
      if ($countones(gray_code ^ prev_g) !== 1) begin
        tests_failed++;
        $display("FAIL seq_one_bit[%0d]: gray %b -> %b, required one bit change", i, prev_g, gray_code);
      end
      prev_g = gray_code;
    end
  endtask

  task automatic test_enable_hold();
    do_reset();
    en = 1'b1;
    for (int i = 0; i < 5; i++) step();
    tests_run++;
    if (count !== 4'd5 || gray_code !== 4'd7) begin
      tests_failed++;
      $display("FAIL hold_reach5: count=%0d gray=%0d required 5/7", count, gray_code);
    end
    en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      tests_run++;
      if (count !== 4'd5 || gray_code !== 4'd7) begin
        tests_failed++;
        $display("FAIL hold_idle[%0d]: count=%0d gray=%0d required 5/7", i, count, gray_code);
      end
    end
    en = 1'b1;
    step();
    tests_run++;
    if (count !== 4'd6 || gray_code !== 4'd5) begin
      tests_failed++;
      $display("FAIL hold_resume: count=%0d gray=%0d required 6/5", count, gray_code);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    en = 1'b1;
    for (int i = 0; i < 10; i++) step();
    tests_run++;
    if (count !== 4'd10 || gray_code !== 4'd15) begin
      tests_failed++;
      $display("FAIL async_reach10: count=%0d gray=%0d required 10/15", count, gray_code);
    end
    // Pulse reset between edges (edges fall on multiples of 10 ns + 5).
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (count !== 4'd0 || gray_code !== 4'd0) begin
      tests_failed++;
      $display("FAIL async_clear: count=%0d gray=%0d required 0/0", count, gray_code);
    end
    #1;
    rst_n = 1'b1;
    step();
    tests_run++;
    if (count !== 4'd1 || gray_code !== 4'd1) begin
      tests_failed++;
      $display("FAIL async_resume: count=%0d gray=%0d required 1/1", count, gray_code);
    end
  endtask

  task automatic test_alternating();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      en = (i % 2 == 0) ? 1'b1 : 1'b0;
      step();
    end
    tests_run++;
    if (count !== 4'd4 || gray_code !== 4'd6) begin
      tests_failed++;
      $display("FAIL alternating: count=%0d gray=%0d required 4/6", count, gray_code);
    end
  endtask

  task automatic test_random_enable();
    logic [W-1:0] exp_c;
    logic [W-1:0] want;
    logic [W-1:0] prev_g;
    logic         cur_en;
    do_reset();
    exp_c  = '0;
    prev_g = '0;
    for (int i = 0; i < 1000; i++) begin
      cur_en = 1'($urandom_range(0, 1));
      en     = cur_en;
      if (cur_en) exp_c = exp_c + 4'd1;
      exp_q.push_back(exp_c);
      step();
      want = exp_q.pop_front();
      tests_run++;
      if (count !== want) begin
        tests_failed++;
        $display("FAIL rand_count[%0d]: got %0d required %0d", i, count, want);
      end
      tests_run++;
      if (gray_code !== model_gray(want)) begin
        tests_failed++;
        $display("FAIL rand_gray[%0d]: got %0d required %0d", i, gray_code, model_gray(want));
      end
      if (cur_en) begin
        tests_run++;
        if ($countones(gray_code ^ prev_g) !== 1) begin
          tests_failed++;
          $display("FAIL rand_one_bit[%0d]: gray %b -> %b", i, prev_g, gray_code);
        end
      end
      prev_g = gray_code;
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n        = 1'b0;
    en           = 1'b0;
    test_reset();
    test_full_sequence();
    test_enable_hold();
    test_async_reset();
    test_alternating();
    test_random_enable();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
